// File: rtl/id_stage_param.sv
// Instruction-decode stage: register file with optional write-through bypass,
// load-use stall, branch flush, immediate extension, ID/EX register, event counters.
module id_stage_param #(
    parameter int DATA_W = 16,
    parameter int AW     = 3,
    parameter int CTRL_W = 15,
    parameter int BYPASS = 1,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              valid_in,
    input  logic [DATA_W-1:0] pc_in,
    input  logic [DATA_W-1:0] pc2_in,
    input  logic [AW-1:0]     rs_sel,
    input  logic [AW-1:0]     rt_sel,
    input  logic [AW-1:0]     wr_sel,
    input  logic              uses_rs,
    input  logic              uses_rt,
    input  logic              reg_write_in,
    input  logic              mem_read_in,
    input  logic [CTRL_W-1:0] ctrl_in,
    input  logic [10:0]       imm_field,
    input  logic [1:0]        imm_size,
    input  logic              zero_ex,
    input  logic              wb_en,
    input  logic [AW-1:0]     wb_sel,
    input  logic [DATA_W-1:0] wb_data,
    input  logic              flush,
    input  logic              freeze,
    output logic              stall_out,
    output logic              valid_ex,
    output logic [DATA_W-1:0] pc_ex,
    output logic [DATA_W-1:0] pc2_ex,
    output logic [DATA_W-1:0] rs_data_ex,
    output logic [DATA_W-1:0] rt_data_ex,
    output logic [DATA_W-1:0] imm_ex,
    output logic [AW-1:0]     rs_sel_ex,
    output logic [AW-1:0]     rt_sel_ex,
    output logic [AW-1:0]     wr_sel_ex,
    output logic              reg_write_ex,
    output logic              mem_read_ex,
    output logic [CTRL_W-1:0] ctrl_ex,
    output logic [CNT_W-1:0]  stall_cnt,
    output logic [CNT_W-1:0]  flush_cnt,
    output logic              err
);
    localparam int NREGS = 2 ** AW;
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    typedef struct packed {
        logic              valid;
        logic [DATA_W-1:0] pc;
        logic [DATA_W-1:0] pc2;
        logic [DATA_W-1:0] rs_data;
        logic [DATA_W-1:0] rt_data;
        logic [DATA_W-1:0] imm;
        logic [AW-1:0]     rs_sel;
        logic [AW-1:0]     rt_sel;
        logic [AW-1:0]     wr_sel;
        logic              reg_write;
        logic              mem_read;
        logic [CTRL_W-1:0] ctrl;
    } idex_t;

    logic [DATA_W-1:0] rf_q [NREGS];
    idex_t             idex_q, idex_d;
    logic [CNT_W-1:0]  stall_cnt_q, stall_cnt_d;
    logic [CNT_W-1:0]  flush_cnt_q, flush_cnt_d;
    logic              err_q, err_d;

    logic [DATA_W-1:0] rs_rd, rt_rd, imm_ext;
    logic              imm_bad;
    logic              sx;
    logic              kill;

    // Bypass makes a same-cycle writeback visible without waiting for the edge.
    always_comb begin
        rs_rd = rf_q[rs_sel];
        rt_rd = rf_q[rt_sel];
        if (BYPASS != 0 && wb_en && wb_sel == rs_sel) rs_rd = wb_data;
        if (BYPASS != 0 && wb_en && wb_sel == rt_sel) rt_rd = wb_data;
    end

    always_comb begin
        imm_ext = '0;
        imm_bad = 1'b0;
        sx      = ~zero_ex;
        case (imm_size)
            2'b00:   imm_ext = {{(DATA_W-5){sx & imm_field[4]}}, imm_field[4:0]};
            2'b01:   imm_ext = {{(DATA_W-8){sx & imm_field[7]}}, imm_field[7:0]};
            2'b10:   imm_ext = {{(DATA_W-11){sx & imm_field[10]}}, imm_field[10:0]};
            default: imm_bad = valid_in;
        endcase
    end

    assign stall_out = valid_in & idex_q.valid & idex_q.mem_read & idex_q.reg_write & ~flush &
                       ((uses_rs & (rs_sel == idex_q.wr_sel)) |
                        (uses_rt & (rt_sel == idex_q.wr_sel)));

    always_comb begin
        idex_d      = idex_q;
        stall_cnt_d = stall_cnt_q;
        flush_cnt_d = flush_cnt_q;
        err_d       = err_q;
        kill        = flush | stall_out | ~valid_in;
        if (!freeze) begin
            // Data, selects and PCs load even into a bubble; only control is squashed.
            idex_d.pc        = pc_in;
            idex_d.pc2       = pc2_in;
            idex_d.rs_data   = rs_rd;
            idex_d.rt_data   = rt_rd;
            idex_d.imm       = imm_ext;
            idex_d.rs_sel    = rs_sel;
            idex_d.rt_sel    = rt_sel;
            idex_d.wr_sel    = wr_sel;
            idex_d.valid     = ~kill;
            idex_d.reg_write = reg_write_in & ~kill;
            idex_d.mem_read  = mem_read_in & ~kill;
            idex_d.ctrl      = kill ? '0 : ctrl_in;
            if (stall_out && stall_cnt_q != CNT_MAX) stall_cnt_d = stall_cnt_q + 1'b1;
            if (flush && valid_in && flush_cnt_q != CNT_MAX) flush_cnt_d = flush_cnt_q + 1'b1;
            if (imm_bad) err_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            idex_q      <= '0;
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
            err_q       <= 1'b0;
            for (int i = 0; i < NREGS; i++) rf_q[i] <= '0;
        end else begin
            idex_q      <= idex_d;
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
            err_q       <= err_d;
            if (wb_en && !freeze) rf_q[wb_sel] <= wb_data;
        end
    end

    assign valid_ex     = idex_q.valid;
    assign pc_ex        = idex_q.pc;
    assign pc2_ex       = idex_q.pc2;
    assign rs_data_ex   = idex_q.rs_data;
    assign rt_data_ex   = idex_q.rt_data;
    assign imm_ex       = idex_q.imm;
    assign rs_sel_ex    = idex_q.rs_sel;
    assign rt_sel_ex    = idex_q.rt_sel;
    assign wr_sel_ex    = idex_q.wr_sel;
    assign reg_write_ex = idex_q.reg_write;
    assign mem_read_ex  = idex_q.mem_read;
    assign ctrl_ex      = idex_q.ctrl;
    assign stall_cnt    = stall_cnt_q;
    assign flush_cnt    = flush_cnt_q;
    assign err          = err_q;

endmodule
